alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Control FSM that strobes a bus datapath through one R-R ALU op.
//            Define MULDIV_EN to add the LO/HI write-back state (T6).
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter logic [4:0] MUL_OP = 5'b01110,
    parameter logic [4:0] DIV_OP = 5'b01111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic        busy,
    output logic        done,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        ZLOin,
    output logic        ZLOout,
    output logic        PCin,
    output logic        MDRread,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
`ifdef MULDIV_EN
    output logic        LOin,
    output logic        HIin,
    output logic        ZHIout,
`endif
    output logic [4:0]  ALU_opcode
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6
`ifdef MULDIV_EN
        ,T6  = 3'd7
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_ra;
    logic [3:0] r_rc;
    logic [4:0] r_op;

`ifdef MULDIV_EN
    logic w_muldiv;
    assign w_muldiv = (r_op == MUL_OP) || (r_op == DIV_OP);
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, ir[14:0]};
`else
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, ir[14:0], MUL_OP, DIV_OP};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = T0;
            T0:   w_next = T1;
            T1:   if (mem_rdy) w_next = T2;
            T2:   w_next = T3;
            T3:   w_next = T4;
            T4:   w_next = T5;
`ifdef MULDIV_EN
            T5:   w_next = w_muldiv ? T6 : IDLE;
            T6:   w_next = IDLE;
`else
            T5:   w_next = IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so each strobe is valid for
    // the whole cycle its state is resident.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_ra       <= 4'd0;
            r_rc       <= 4'd0;
            r_op       <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            PCout      <= 1'b0;
            MARin      <= 1'b0;
            IncPC      <= 1'b0;
            Zin        <= 1'b0;
            ZLOin      <= 1'b0;
            ZLOout     <= 1'b0;
            PCin       <= 1'b0;
            MDRread    <= 1'b0;
            MDRin      <= 1'b0;
            MDRout     <= 1'b0;
            IRin       <= 1'b0;
            Yin        <= 1'b0;
            Rout       <= 16'h0000;
            Rin        <= 16'h0000;
            ALU_opcode <= 5'd0;
`ifdef MULDIV_EN
            LOin       <= 1'b0;
            HIin       <= 1'b0;
            ZHIout     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == T2) begin
                r_ra <= ir[26:23];
                r_rc <= ir[18:15];
                r_op <= ir[31:27];
            end
            busy       <= (w_next != IDLE);
            done       <= 1'b0;
            PCout      <= 1'b0;
            MARin      <= 1'b0;
            IncPC      <= 1'b0;
            Zin        <= 1'b0;
            ZLOin      <= 1'b0;
            ZLOout     <= 1'b0;
            PCin       <= 1'b0;
            MDRread    <= 1'b0;
            MDRin      <= 1'b0;
            MDRout     <= 1'b0;
            IRin       <= 1'b0;
            Yin        <= 1'b0;
            Rout       <= 16'h0000;
            Rin        <= 16'h0000;
            ALU_opcode <= 5'd0;
`ifdef MULDIV_EN
            LOin       <= 1'b0;
            HIin       <= 1'b0;
            ZHIout     <= 1'b0;
`endif
            case (w_next)
                T0: begin
                    PCout <= 1'b1;
                    MARin <= 1'b1;
                    IncPC <= 1'b1;
                    Zin   <= 1'b1;
                    ZLOin <= 1'b1;
                end
                T1: begin
                    ZLOout  <= 1'b1;
                    PCin    <= (r_state == T0);
                    MDRread <= 1'b1;
                    MDRin   <= 1'b1;
                end
                T2: begin
                    MDRout <= 1'b1;
                    IRin   <= 1'b1;
                end
                // Entered only from T2: Rb is taken at the same edge the fields are captured.
                T3: begin
                    Rout <= 16'h0001 << ir[22:19];
                    Yin  <= 1'b1;
                end
                T4: begin
                    Rout       <= 16'h0001 << r_rc;
                    Zin        <= 1'b1;
                    ZLOin      <= 1'b1;
                    ALU_opcode <= r_op;
                end
                T5: begin
                    ZLOout <= 1'b1;
`ifdef MULDIV_EN
                    if (w_muldiv) begin
                        LOin <= 1'b1;
                    end else begin
                        Rin  <= 16'h0001 << r_ra;
                        done <= 1'b1;
                    end
`else
                    Rin  <= 16'h0001 << r_ra;
                    done <= 1'b1;
`endif
                end
`ifdef MULDIV_EN
                T6: begin
                    ZHIout <= 1'b1;
                    HIin   <= 1'b1;
                    done   <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Scoreboard bench for alu_op_sequencer (honours MULDIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam logic [4:0] C_MUL = 5'b01110;
    localparam logic [4:0] C_DIV = 5'b01111;
    localparam logic [11:0] C_PCOUT = 12'h800, C_MARIN = 12'h400, C_INCPC = 12'h200,
                            C_ZIN = 12'h100, C_ZLOIN = 12'h080, C_ZLOOUT = 12'h040,
                            C_PCIN = 12'h020, C_MDRRD = 12'h010, C_MDRIN = 12'h008,
                            C_MDROUT = 12'h004, C_IRIN = 12'h002, C_YIN = 12'h001;

    typedef logic [53:0] obs_t;

    logic clk = 1'b0, clr = 1'b1, start = 1'b0, mem_rdy = 1'b0;
    logic [31:0] ir = 32'h0;
    logic busy, done, PCout, MARin, IncPC, Zin, ZLOin, ZLOout, PCin;
    logic MDRread, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rout, Rin;
    logic [4:0] ALU_opcode;
    logic [2:0] md;

    always #5 clk = ~clk;

    alu_op_sequencer #(.MUL_OP(C_MUL), .DIV_OP(C_DIV)) dut (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy), .done(done), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
        .Zin(Zin), .ZLOin(ZLOin), .ZLOout(ZLOout), .PCin(PCin), .MDRread(MDRread),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Rout(Rout),
        .Rin(Rin),
`ifdef MULDIV_EN
        .LOin(md[2]), .HIin(md[1]), .ZHIout(md[0]),
`endif
        .ALU_opcode(ALU_opcode)
    );
`ifndef MULDIV_EN
    assign md = 3'b000;
`endif

    obs_t w_obs;
    assign w_obs = {busy, done, PCout, MARin, IncPC, Zin, ZLOin, ZLOout, PCin,
                    MDRread, MDRin, MDRout, IRin, Yin, Rout, Rin, ALU_opcode, md};

    obs_t sb[$];
    int   n_checks = 0, n_errors = 0, n_done = 0, exp_done = 0;
    bit   mon_en = 1'b0;

    function automatic obs_t mk(input bit b, input bit d, input logic [11:0] s,
                                input logic [15:0] ro, input logic [15:0] ri,
                                input logic [4:0] op, input logic [2:0] m);
        return {b, d, s, ro, ri, op, m};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every busy cycle consumes one expected record; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (sb.size() == 0) check("unexpected_busy", w_obs, '0);
                else check("busy_cycle", w_obs, sb.pop_front());
            end else begin
                check("idle_cycle", w_obs, '0);
            end
            if (done === 1'b1) n_done++;
        end
    end

    // One instruction: the expected cycle-by-cycle response is the T0..T5(T6)
    // recipe; clr_pos aborts after that many busy cycles (-1 = no abort).
    task automatic run_instr(input logic [4:0] op, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [3:0] rc,
                             input int w, input bit chg_ir, input bit start_t3,
                             input int clr_pos);
        obs_t exp[$];
        logic [31:0] ir_base, ir_new;
        bit   is_md;
        int   limit, cpos;
`ifdef MULDIV_EN
        is_md = (op == C_MUL) || (op == C_DIV);
`else
        is_md = 1'b0;
`endif
        exp.push_back(mk(1, 0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN | C_ZLOIN, 0, 0, 0, 0));
        for (int i = 0; i <= w; i++)
            exp.push_back(mk(1, 0, C_ZLOOUT | C_MDRRD | C_MDRIN | ((i == 0) ? C_PCIN : 12'h0),
                             0, 0, 0, 0));
        exp.push_back(mk(1, 0, C_MDROUT | C_IRIN, 0, 0, 0, 0));
        exp.push_back(mk(1, 0, C_YIN, 16'h1 << rb, 0, 0, 0));
        exp.push_back(mk(1, 0, C_ZIN | C_ZLOIN, 16'h1 << rc, 0, op, 0));
        if (is_md) begin
            exp.push_back(mk(1, 0, C_ZLOOUT, 0, 0, 0, 3'b100));
            exp.push_back(mk(1, 1, 12'h0, 0, 0, 0, 3'b011));
        end else begin
            exp.push_back(mk(1, 1, C_ZLOOUT, 0, 16'h1 << ra, 0, 0));
        end
        cpos  = (clr_pos > exp.size()) ? -1 : clr_pos;
        limit = (cpos < 0) ? exp.size() : cpos;
        for (int i = 0; i < limit; i++) begin
            sb.push_back(exp[i]);
            if (exp[i][52]) exp_done++;
        end

        ir_base = {op, ra, rb, rc, 15'($urandom_range(0, 32767))};
        ir_new  = $urandom;
        ir_new[26:23] = 4'd7;
        for (int k = 0; k <= limit + 3; k++) begin
            @(posedge clk); #1;
            if (k == 0)                      start = 1'b1;
            else if (start_t3 && k == 4 + w) start = 1'b1;
            else if (k <= limit)             start = 1'($urandom_range(0, 1));
            else                             start = 1'b0;
            if (k >= 2 && k <= 2 + w) mem_rdy = (k == 2 + w);
            else                      mem_rdy = 1'($urandom_range(0, 1));
            ir  = (chg_ir && k >= 4 + w) ? ir_new : ir_base;
            clr = (k == cpos);
        end
        @(negedge clk); #1;
        check_int("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int w, cp;
        logic [4:0] op;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        run_instr(5'b00101, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, -1);   // basic AND
        run_instr(5'b00101, 4'd1, 4'd2, 4'd3, 3, 1'b0, 1'b0, -1);   // memory wait
        run_instr(5'b00101, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b1, -1);   // start in T3
        run_instr(5'b00101, 4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b0, 6);    // clr in T4
        run_instr(C_MUL,    4'd4, 4'd5, 4'd6, 0, 1'b0, 1'b0, -1);   // multiply
        run_instr(C_DIV,    4'd0, 4'd15, 4'd0, 2, 1'b0, 1'b0, -1);  // divide, index 0/15
        run_instr(5'b00101, 4'd1, 4'd2, 4'd3, 0, 1'b1, 1'b0, -1);   // IR change in T3

        // clr beats start while idle
        @(posedge clk); #1 clr = 1'b1; start = 1'b1;
        @(posedge clk); #1 clr = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            w  = $urandom_range(0, 3);
            op = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? C_MUL : C_DIV)
                                             : 5'($urandom_range(0, 31));
            cp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7 + w) : -1;
            run_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), w, 1'($urandom_range(0, 1)),
                      1'b0, cp);
        end

        check_int("done_count", n_done, exp_done);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
